// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: Start/Busy/Done handshake and operand/result bus of the divider
interface seq_restoring_divider_if #(parameter int N = 8);
  logic         Start;
  logic [N-1:0] Dividend;
  logic [N-1:0] Divisor;
  logic         Busy;
  logic         Done;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         Div_By_Zero;
  modport master (output Start, Dividend, Divisor, input Busy, Done, Quotient, Remainder, Div_By_Zero);
  modport slave (input Start, Dividend, Divisor, output Busy, Done, Quotient, Remainder, Div_By_Zero);
endinterface

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned N-bit restoring divider, one quotient bit per clock
module seq_restoring_divider #(parameter int N = 8) (
  input  logic Clk,
  input  logic Rst,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state, state_n;
  // {R, Q} with R's MSB dropped: R < Divisor always, so that bit is constant zero
  logic [2*N-1:0] rq, rq_n;
  logic [N:0]     t;
  logic [N-1:0]   dvs, quotient, remainder;
  logic [CW-1:0]  cnt;
  logic           dbz, accept, last;
  assign accept = bus.Start && state != CALC;
  assign last = cnt == CW'(N - 1);
  always_comb begin
    t = rq[2*N-1:N-1] - {1'b0, dvs};
    rq_n = t[N] ? {rq[2*N-2:0], 1'b0} : {t[N-1:0], rq[N-2:0], 1'b1};
    state_n = state == CALC ? (last ? FIN : CALC)
            : accept ? (bus.Divisor == '0 ? FIN : CALC) : IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rq <= '0;
      dvs <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      dbz <= 1'b0;
    end else if (accept) begin
      dvs <= bus.Divisor;
      rq <= {{N{1'b0}}, bus.Dividend};
      cnt <= '0;
      if (bus.Divisor == '0) begin
        quotient <= '1;
        remainder <= bus.Dividend;
        dbz <= 1'b1;
      end
    end else if (state == CALC) begin
      rq <= rq_n;
      cnt <= cnt + CW'(1);
      if (last) begin
        quotient <= rq_n[N-1:0];
        remainder <= rq_n[2*N-1:N];
        dbz <= 1'b0;
      end
    end
  end
  assign bus.Busy = state == CALC;
  assign bus.Done = state == FIN;
  assign bus.Quotient = quotient;
  assign bus.Remainder = remainder;
  assign bus.Div_By_Zero = dbz;
endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned N-bit divider built on one shared N+1-bit trial subtractor; retires one quotient bit per clock (restoring algorithm).
- Companion to the combinational add/subtract datapath: covers the inverse operation the arithmetic library lacks, with a Start/Busy/Done handshake for sequential control logic.

Parameters:
N, 8, operand width in bits for Dividend, Divisor, Quotient and Remainder (N >= 2)

Ports:
Clk  input  1  rising-edge clock, the only clock
Rst  input  1  synchronous, active-high reset
Start  input  1  request; sampled only when Busy=0
Dividend  input  N  unsigned dividend, captured on accepted Start
Divisor  input  N  unsigned divisor, captured on accepted Start
Busy  output  1  high while an operation is in progress
Done  output  1  one-cycle pulse; results valid this cycle
Quotient  output  N  unsigned quotient, registered
Remainder  output  N  unsigned remainder, registered
Div_By_Zero  output  1  set with Done when captured Divisor was 0

Behaviour:
- One clock domain. Reset is synchronous and active-high: on a Clk edge with Rst=1, the state goes to IDLE and Busy, Done, Quotient, Remainder and Div_By_Zero all go to 0. Rst overrides Start and any in-flight operation, and a mid-operation reset discards it silently.
- States: IDLE, CALC, FIN.
- IDLE or FIN with Start=1 at edge k (accept):
  - Latch Divisor.
  - Load the working register {R[N:0], Q[N-1:0]} = {0, Dividend}.
  - Clear the iteration counter (ceil(log2 N)+1 bits).
  - If Divisor != 0, go to CALC with Busy=1 from edge k.
  - If Divisor == 0, go to FIN directly: Quotient = all ones, Remainder = Dividend, Div_By_Zero = 1, Done = 1 in the cycle after edge k, Busy stays 0.
- CALC, each edge:
  - Shift {R,Q} left by 1.
  - Trial T = R_shifted - {0,Divisor} (N+1 bits).
  - If T[N] = 0, then R = T and Q[0] = 1; otherwise keep R_shifted and set Q[0] = 0.
  - Counter increments.
  - On the edge completing iteration N (edge k+N): Quotient = Q, Remainder = R[N-1:0], Div_By_Zero = 0, go to FIN, Busy = 0.
- FIN: Done = 1 for exactly one cycle. The next edge goes to IDLE, or back to CALC or FIN if Start=1 (back-to-back accepted).
- Latency: Done is high in cycle k+N+1 for normal operation and cycle k+1 for divide-by-zero. Throughput is one result per N+1 cycles.
- Start while Busy=1 is ignored, with no effect on state or captured operands. Dividend and Divisor may change freely after acceptance.
- Quotient, Remainder and Div_By_Zero hold their last values until the next result is written. They are not cleared on Start.
- Invariant for Divisor != 0: Dividend = Quotient*Divisor + Remainder, with Remainder < Divisor.
- Done and Busy are never high in the same cycle.

Test Plan:
- N=8: reset, then Start with 100/7 -> Busy high for 8 cycles, Done in cycle k+9, Quotient=14, Remainder=2, Div_By_Zero=0.
- Boundary operands: 255/1 -> Quotient=255, Remainder=0. 5/9 -> Quotient=0, Remainder=5. 255/255 -> Quotient=1, Remainder=0. 0/3 -> Quotient=0, Remainder=0.
- Divide by zero: 37/0 -> Done in cycle k+1, Quotient=255, Remainder=37, Div_By_Zero=1, Busy never asserted.
- Start pulses with 9/2 during Busy of a 200/13 operation -> ignored; result is Quotient=15, Remainder=5, with exactly one Done.
- Rst=1 at iteration 4 of 200/13 -> next cycle all outputs 0 and state IDLE. A fresh 50/6 then gives Quotient=8, Remainder=2.
- Back-to-back: Start held high through the FIN cycle with 17/4 then 64/8 -> Quotient=4, Remainder=1, then Quotient=8, Remainder=0. Done pulses exactly N+1 cycles apart.
- Random sweep of 10k operand pairs (including divisor 0) -> invariant and flags checked against a reference model.
